// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: main register plus a one-entry skid register.
// in_ready depends only on registered skid state and flush, so an upstream
// stall never sees a combinational path from out_ready through this stage.
module pipe_skid_stage #(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = 64,
  parameter bit DATA_CLR = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  kill_cnt
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              acc, con;
  logic [1:0]        kill_n;
  logic [CNT_W:0]    kill_sum;

  localparam logic [CNT_W:0] KILL_MAX = {1'b0, {CNT_W{1'b1}}};

  assign in_ready  = ~skid_valid & ~flush;
  assign acc       = in_valid & in_ready;
  assign con       = main_valid & out_ready;
  assign count     = {1'b0, main_valid} + {1'b0, skid_valid};
  assign out_valid = main_valid;
  // Bubbles carry zero control so a dead entry can never write state.
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = (DATA_CLR && !main_valid) ? '0 : main_data;

  // Entries still held after this cycle's consume are the ones a flush kills.
  assign kill_n    = count - {1'b0, con};
  assign kill_sum  = {1'b0, kill_cnt} + (CNT_W+1)'(kill_n);

  // Occupancy transitions; flush wins over any load, a concurrent consume
  // is simply not counted as killed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
    end else if (!main_valid) begin
      if (acc) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end
    end else if (!skid_valid) begin
      if (acc && con) begin
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end else if (acc) begin
        skid_valid <= 1'b1;
        skid_ctrl  <= in_ctrl;
        skid_data  <= in_data;
      end else if (con) begin
        main_valid <= 1'b0;
      end
    end else if (con) begin
      main_ctrl  <= skid_ctrl;
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end
  end

  // Saturating debug counter of flushed entries; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      kill_cnt <= '0;
    else if (flush)
      kill_cnt <= (kill_sum > KILL_MAX) ? KILL_MAX[CNT_W-1:0] : kill_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench: two instances share stimulus, one holding data on bubbles
// with a wide kill counter, one clearing data with a 2-bit kill counter.
module tb_pipe_skid_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [15:0] in_data = '0;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [7:0]  a_out_ctrl, b_out_ctrl, a_kill;
  logic [15:0] a_out_data, b_out_data;
  logic [1:0]  a_count, b_count, b_kill;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.CTRL_W(8), .DATA_W(16), .DATA_CLR(1'b0), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .count(a_count), .kill_cnt(a_kill));

  pipe_skid_stage #(.CTRL_W(8), .DATA_W(16), .DATA_CLR(1'b1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .count(b_count), .kill_cnt(b_kill));

  function automatic logic [15:0] dat(input logic [7:0] c);
    return {c, ~c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = dat(c);
  endtask

  // Load two entries with downstream stalled; leaves count=2.
  task automatic fill2(input logic [7:0] c1, input logic [7:0] c2);
    out_ready = 1'b0;
    drive(1'b1, c1); step();
    drive(1'b1, c2); step();
    drive(1'b0, 8'h00);
    chk("fill_cnt", a_count, 2);
    chk("fill_rdy", a_in_ready, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_vld", a_out_valid, 0);
    chk("rst_cnt", a_count, 0);
    chk("rst_kill", a_kill, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_rdy", a_in_ready, 1);
    step();

    // Streaming: one entry per cycle, 1-cycle latency, no bubbles
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i));
      step();
      chk("str_vld", a_out_valid, 1);
      chk("str_ctrl", a_out_ctrl, i);
      chk("str_data", b_out_data, dat(8'(i)));
      chk("str_cnt", a_count, 1);
    end
    drive(1'b0, 8'h00);
    step();
    chk("drain_vld", a_out_valid, 0);
    chk("drain_ctrl", a_out_ctrl, 0);
    chk("drain_cnt", a_count, 0);
    chk("hold_data", a_out_data, dat(8'h10));
    chk("clr_data", b_out_data, 0);

    // Backpressure: A, B fill the stage, C is held off
    out_ready = 1'b0;
    drive(1'b1, 8'hA1); step();
    chk("bp_cnt1", a_count, 1);
    drive(1'b1, 8'hB2); step();
    chk("bp_cnt2", a_count, 2);
    chk("bp_rdy0", a_in_ready, 0);
    drive(1'b1, 8'hC3); step();
    chk("bp_hold_ctrl", a_out_ctrl, 8'hA1);
    chk("bp_hold_cnt", a_count, 2);
    out_ready = 1'b1;
    step();
    chk("bp_b_ctrl", a_out_ctrl, 8'hB2);
    chk("bp_rdy1", a_in_ready, 1);
    chk("bp_b_cnt", a_count, 1);
    step();
    chk("bp_c_ctrl", a_out_ctrl, 8'hC3);
    chk("bp_c_data", a_out_data, dat(8'hC3));
    drive(1'b0, 8'h00);
    step();
    chk("bp_empty", a_count, 0);

    // Flush with two entries and no consume: both killed
    fill2(8'h11, 8'h22);
    flush = 1'b1;
    #1;
    chk("fl_rdy", a_in_ready, 0);
    step();
    flush = 1'b0;
    chk("fl_cnt", a_count, 0);
    chk("fl_vld", a_out_valid, 0);
    chk("fl_ctrl", b_out_ctrl, 0);
    chk("fl_kill_a", a_kill, 2);
    chk("fl_kill_b", b_kill, 2);
    chk("fl_data_b", b_out_data, 0);
    chk("fl_data_a", a_out_data, dat(8'h11));

    // Flush with consume in the same cycle: head delivered, one killed
    fill2(8'h33, 8'h44);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("flc_vld", a_out_valid, 1);
    chk("flc_ctrl", a_out_ctrl, 8'h33);
    step();
    flush = 1'b0;
    chk("flc_cnt", a_count, 0);
    chk("flc_kill_a", a_kill, 3);
    chk("flc_kill_b", b_kill, 3);

    // Flush vs accept on an empty stage: nothing captured, nothing killed
    drive(1'b1, 8'h55);
    flush = 1'b1;
    #1;
    chk("fva_rdy", b_in_ready, 0);
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00);
    chk("fva_vld", a_out_valid, 0);
    chk("fva_kill_a", a_kill, 3);

    // Saturation of the 2-bit counter across further double kills
    for (int k = 0; k < 2; k++) begin
      fill2(8'h60 + 8'(k), 8'h70 + 8'(k));
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("sat_kill_a", a_kill, 5 + 2 * k);
      chk("sat_kill_b", b_kill, 3);
      chk("sat_data_b", b_out_data, 0);
    end

    // Async reset mid-stall with count=2
    fill2(8'h81, 8'h92);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", a_out_valid, 0);
    chk("arst_ctrl", a_out_ctrl, 0);
    chk("arst_data_a", a_out_data, 0);
    chk("arst_data_b", b_out_data, 0);
    chk("arst_cnt", b_count, 0);
    chk("arst_kill_a", a_kill, 0);
    chk("arst_kill_b", b_kill, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("arst_rdy", a_in_ready, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline stage register. Successor to the fixed inter-stage registers: one generic block carries any stage's control and datapath bundle.
- Adds a valid/ready handshake with a 2-entry skid buffer. Upstream stalls then use only registered ready, with no combinational ready path through the stage.
- Keeps synchronous flush for branch/jump kill and counts entries killed by flush for debug.

Parameters:
- CTRL_W, 8: control bundle width (RegWrite, MemRW, WBSel, PCSel, etc.). Forced to 0 whenever the entry is invalid.
- DATA_W, 64: datapath bundle width (alu, rd2, pc, pc4, rd, etc.).
- DATA_CLR, 0: 1 = out_data forced to 0 when out_valid=0; 0 = out_data holds its last value.
- CNT_W, 8: width of the kill counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of all entries held in this stage
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; equals ~skid_valid & ~flush
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream datapath bundle
- out_valid  out  1  registered; main entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  main entry control; 0 when out_valid=0
- out_data  out  DATA_W  main entry datapath
- count  out  2  occupancy, 0..2
- kill_cnt  out  CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- Storage:
  - Main register (out_*) always holds the oldest entry.
  - Skid register holds the younger entry.
  - count = main_valid + skid_valid.
- Handshakes:
  - acc = in_valid & in_ready.
  - con = out_valid & out_ready.
  - A transfer completes only on a rising edge with the handshake high.
  - in_valid and in_ctrl/in_data are ignored when in_ready=0.
- Transitions (no flush):
  - count0: acc → main loads input, count1.
  - count1: acc & con → main loads input, count1. acc only → skid loads input, count2. con only → count0. Neither → hold.
  - count2: in_ready=0. con → main loads skid, skid invalid, count1. No con → hold.
- Latency and throughput:
  - Latency 1 cycle from accept to out_valid.
  - Sustained throughput 1 entry/cycle while out_ready=1.
  - Order is strictly FIFO.
- Flush (highest priority):
  - A con in the flush cycle completes normally; downstream owns that entry.
  - In the flush cycle, in_ready=0, so no accept occurs.
  - Next edge: main and skid both invalid, out_ctrl=0, out_data=0 if DATA_CLR=1, count=0.
  - kill_cnt += number of entries still held and not consumed that cycle, i.e. count − con, range 0..2.
- kill_cnt:
  - Saturates at 2^CNT_W−1; never wraps.
  - Cleared only by rst.
- Invalid entries:
  - out_ctrl is always 0 when out_valid=0, so bubbles are benign.
  - Skid contents are don't-care when skid is invalid.
- Reset (async, any time, including mid-stall or mid-flush):
  - out_valid=0, out_ctrl=0, out_data=0, skid cleared, count=0, kill_cnt=0.
  - in_ready=1 once rst deasserts, provided flush=0.
- Consistency:
  - count never exceeds 2.
  - No entry is duplicated or lost except by flush.

Test Plan:
- Reset: assert rst mid-stream with count=2 → outputs zero immediately (async), count=0, kill_cnt=0; after release, in_ready=1.
- Streaming: out_ready=1, inputs ctrl 0x01..0x10 on consecutive cycles → each appears on out_ctrl exactly 1 cycle later, in order, with no bubbles; count stays 1.
- Backpressure: out_ready=0, send A then B → count=2, in_ready=0, C held off. Raise out_ready → A, B, C emerge in order; in_ready returns 1 the cycle after A is consumed.
- Flush with entries: count=2, out_ready=0, flush=1 → next cycle count=0, out_valid=0, out_ctrl=0, kill_cnt=2. Repeat with out_ready=1 in the flush cycle → A delivered, kill_cnt +1.
- Flush vs accept: flush=1 with in_valid=1, count=0 → in_ready=0, entry not captured, out_valid=0 next cycle, kill_cnt unchanged.
- Saturation: CNT_W=2, issue 3 flushes each killing 2 entries → kill_cnt reads 3 and stays 3; with DATA_CLR=1, out_data=0 after each flush.
